// File: rtl/conv_window_3x3.sv
// conv_window_3x3: raster 3x3 sliding-window generator (two line buffers, shift window; `CONV_WIN_STRIDE2_EN gates win_valid to stride 2) -- in: clk rst en in_valid pix_in, out: win1..win9 win_valid frame_done
module conv_window_3x3 #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pix_in,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic [DATA_W-1:0] win9,
  output logic              win_valid,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic acc, col_end, row_end, emit;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] rd0, rd1;
  logic [DATA_W-1:0] w_q [9];
  always_comb begin
    acc = en && in_valid;
    col_end = col_q == CW'(IMG_WIDTH - 1);
    row_end = row_q == RW'(IMG_HEIGHT - 1);
    col_d = !acc ? col_q : col_end ? '0 : col_q + CW'(1);
    row_d = (!acc || !col_end) ? row_q : row_end ? '0 : row_q + RW'(1);
    rd0 = lb0[col_q];
    rd1 = lb1[col_q];
`ifdef CONV_WIN_STRIDE2_EN
    emit = acc && row_q >= RW'(2) && col_q >= CW'(2) && !row_q[0] && !col_q[0];
`else
    emit = acc && row_q >= RW'(2) && col_q >= CW'(2);
`endif
  end
  always_ff @(posedge clk)
    if (acc) begin
      lb0[col_q] <= rd1;
      lb1[col_q] <= pix_in;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
      w_q <= '{default: '0};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_valid <= emit;
      frame_done <= acc && col_end && row_end;
      if (acc) w_q <= '{w_q[1], w_q[2], rd0, w_q[4], w_q[5], rd1, w_q[7], w_q[8], pix_in};
    end
  assign win1 = w_q[0];
  assign win2 = w_q[1];
  assign win3 = w_q[2];
  assign win4 = w_q[3];
  assign win5 = w_q[4];
  assign win6 = w_q[5];
  assign win7 = w_q[6];
  assign win8 = w_q[7];
  assign win9 = w_q[8];
endmodule

// File: tb/tb_conv_window_3x3.sv
// tb_conv_window_3x3: scoreboard bench for conv_window_3x3 on a small frame
module tb_conv_window_3x3;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int W = 5, H = 5;
  int tab [4][9] = '{'{1,2,3,6,7,8,11,12,13}, '{3,4,5,8,9,10,13,14,15},
                     '{11,12,13,16,17,18,21,22,23}, '{13,14,15,18,19,20,23,24,25}};
  int trig [4] = '{12, 14, 22, 24};
`else
  localparam int W = 4, H = 4;
  int tab [4][9] = '{'{1,2,3,5,6,7,9,10,11}, '{2,3,4,6,7,8,10,11,12},
                     '{5,6,7,9,10,11,13,14,15}, '{6,7,8,10,11,12,14,15,16}};
  int trig [4] = '{10, 11, 14, 15};
`endif
  localparam int N = W * H;
  typedef struct packed {
    logic [8:0][7:0] p;
    logic fd;
    logic [31:0] at;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic clk = 0, rst = 1, en = 1, in_valid = 0;
  logic [7:0] pix_in = 0;
  logic [7:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
  logic win_valid, frame_done;
  logic [8:0][7:0] w, last;
  logic [31:0] cyc = 0;
  logic acc_s, have_last = 0;
  int errors = 0, checks = 0;
  conv_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .pix_in(pix_in),
    .win1(win1), .win2(win2), .win3(win3), .win4(win4), .win5(win5),
    .win6(win6), .win7(win7), .win8(win8), .win9(win9),
    .win_valid(win_valid), .frame_done(frame_done));
  assign w = {win9, win8, win7, win6, win5, win4, win3, win2, win1};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst) acc_s <= rst ? 1'b0 : (en && in_valid);
  always @(negedge clk) begin
    if (rst) have_last = 0;
    else if (win_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window cyc=%0d got=%h", cyc, w);
      end else begin
        e = q.pop_front();
        if (w !== e.p || frame_done !== e.fd || cyc !== e.at) begin
          errors++;
          $display("FAIL window cyc=%0d got=%h fd=%b, want=%h fd=%b cyc=%0d", cyc, w, frame_done, e.p, e.fd, e.at);
        end
        last = e.p;
        have_last = 1;
      end
    end else begin
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_alone cyc=%0d got=%b want=0", cyc, frame_done);
      end
      if (acc_s) have_last = 0;
      else if (have_last) begin
        checks++;
        if (w !== last) begin
          errors++;
          $display("FAIL hold cyc=%0d got=%h want=%h", cyc, w, last);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string name);
    checks++;
    if (w !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got win=%h v=%b fd=%b want all 0", name, w, win_valid, frame_done);
    end
  endtask
  task automatic send_frame(input int base, input int n, input int gap, input int en_off_at);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      if (i == en_off_at) begin
        en = 0;
        in_valid = 1;
        pix_in = 8'hAA;
        repeat (3) step();
        en = 1;
      end
      in_valid = 1;
      pix_in = 8'(base + i + 1);
      for (int k = 0; k < 4; k++)
        if (i == trig[k]) begin
          for (int j = 0; j < 9; j++) x.p[j] = 8'(tab[k][j] + base);
          x.fd = (k == 3);
          x.at = cyc + 1;
          q.push_back(x);
        end
      step();
      if (gap > 0) begin
        in_valid = 0;
        repeat (gap) step();
      end
    end
    in_valid = 0;
  endtask
  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_windows got=%0d pending want=0", name, q.size());
      q.delete();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    #1;
    repeat (5) begin
      in_valid = 1'($urandom);
      pix_in = 8'($urandom);
      @(negedge clk);
      check_zero("reset_hold");
    end
    step();
    rst = 0;
    in_valid = 0;
    repeat (10) begin
      @(negedge clk);
      check_zero("idle_after_reset");
    end
    step();
    send_frame(0, N, 0, -1);
    drain("back_to_back");
    send_frame(0, N, 1, trig[0] + 1);
    drain("gapped");
    send_frame(0, N, 0, -1);
    send_frame(N, N, 0, -1);
    drain("two_frames");
    send_frame(0, 7, 0, -1);
    #2 rst = 1;
    #1 check_zero("async_reset");
    step();
    rst = 0;
    send_frame(0, N, 0, -1);
    drain("after_mid_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
